// File: rtl/mem_arbiter.sv
// Two-master (CPU, DMA) arbiter for the shared 16-bit memory/IO bus with fixed wait states.
// Optional feature: define ARB_ROUND_ROBIN_EN to alternate grants on contention instead of fixed CPU priority.
module mem_arbiter #(
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req_in,
  input  logic [15:0] cpu_a_in,
  input  logic [15:0] cpu_d_in,
  input  logic        cpu_wen_in,
  input  logic        cpu_iom_in,
  output logic        cpu_ack_out,
  output logic        cpu_wait_out,
  input  logic        dma_req_in,
  input  logic [15:0] dma_a_in,
  input  logic [15:0] dma_d_in,
  input  logic        dma_wen_in,
  input  logic        dma_iom_in,
  output logic        dma_ack_out,
  output logic [15:0] rdata_out,
  output logic [15:0] mem_a_out,
  output logic [15:0] mem_d_out,
  input  logic [15:0] mem_d_in,
  output logic        mem_wen_out,
  output logic        mem_iom_out
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  typedef enum logic {OWN_CPU, OWN_DMA} owner_e;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

  generate
    if (WAIT_STATES > 15) begin : g_bad_wait_states
      $error("mem_arbiter: WAIT_STATES must be 0..15");
    end
  endgenerate

  state_e     state;
  owner_e     owner;
  owner_e     last_owner;
  logic [3:0] wait_cnt;
  logic       grant_dma;

  assign cpu_wait_out = cpu_req_in & ~cpu_ack_out;

  // NOTE: always_comb assigns a default before any conditional override so no latch is inferred.
  always_comb begin
    grant_dma = dma_req_in & ~cpu_req_in;
`ifdef ARB_ROUND_ROBIN_EN
    if (cpu_req_in && dma_req_in) grant_dma = (last_owner == OWN_CPU);
`endif
  end

`ifndef ARB_ROUND_ROBIN_EN
  // History is still kept under fixed priority; this sink marks it as deliberately unread.
  logic unused_last_owner;
  assign unused_last_owner = last_owner;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      owner       <= OWN_CPU;
      last_owner  <= OWN_DMA;
      wait_cnt    <= '0;
      cpu_ack_out <= 1'b0;
      dma_ack_out <= 1'b0;
      rdata_out   <= '0;
      mem_a_out   <= '0;
      mem_d_out   <= '0;
      mem_wen_out <= 1'b0;
      mem_iom_out <= 1'b0;
    end else begin
      cpu_ack_out <= 1'b0;
      dma_ack_out <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cpu_req_in || dma_req_in) begin
            // The mem_* registers double as the latched request of the granted master.
            owner       <= grant_dma ? OWN_DMA : OWN_CPU;
            last_owner  <= grant_dma ? OWN_DMA : OWN_CPU;
            mem_a_out   <= grant_dma ? dma_a_in   : cpu_a_in;
            mem_d_out   <= grant_dma ? dma_d_in   : cpu_d_in;
            mem_wen_out <= grant_dma ? dma_wen_in : cpu_wen_in;
            mem_iom_out <= grant_dma ? dma_iom_in : cpu_iom_in;
            wait_cnt    <= WAIT_LOAD;
            state       <= BUSY;
          end
        end
        BUSY: begin
          if (wait_cnt == 4'd0) begin
            rdata_out   <= mem_d_in;
            mem_wen_out <= 1'b0;
            cpu_ack_out <= (owner == OWN_CPU);
            dma_ack_out <= (owner == OWN_DMA);
            state       <= DONE;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        DONE: begin
          mem_a_out   <= '0;
          mem_d_out   <= '0;
          mem_wen_out <= 1'b0;
          mem_iom_out <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: one instance with WAIT_STATES=1, one with WAIT_STATES=0.
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // WAIT_STATES=1 instance
  logic        cpu_req, cpu_wen, cpu_iom, dma_req, dma_wen, dma_iom;
  logic [15:0] cpu_a, cpu_d, dma_a, dma_d, mem_rd;
  logic        cpu_ack, cpu_wait, dma_ack, mem_wen, mem_iom;
  logic [15:0] rdata, mem_a, mem_d;

  // WAIT_STATES=0 instance
  logic        z_cpu_req, z_cpu_wen, z_cpu_iom, z_dma_req, z_dma_wen, z_dma_iom;
  logic [15:0] z_cpu_a, z_cpu_d, z_dma_a, z_dma_d, z_mem_rd;
  logic        z_cpu_ack, z_cpu_wait, z_dma_ack, z_mem_wen, z_mem_iom;
  logic [15:0] z_rdata, z_mem_a, z_mem_d;

  mem_arbiter #(.WAIT_STATES(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_in(cpu_req), .cpu_a_in(cpu_a), .cpu_d_in(cpu_d), .cpu_wen_in(cpu_wen),
    .cpu_iom_in(cpu_iom), .cpu_ack_out(cpu_ack), .cpu_wait_out(cpu_wait),
    .dma_req_in(dma_req), .dma_a_in(dma_a), .dma_d_in(dma_d), .dma_wen_in(dma_wen),
    .dma_iom_in(dma_iom), .dma_ack_out(dma_ack), .rdata_out(rdata),
    .mem_a_out(mem_a), .mem_d_out(mem_d), .mem_d_in(mem_rd),
    .mem_wen_out(mem_wen), .mem_iom_out(mem_iom)
  );

  mem_arbiter #(.WAIT_STATES(0)) u_dut_w0 (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_in(z_cpu_req), .cpu_a_in(z_cpu_a), .cpu_d_in(z_cpu_d), .cpu_wen_in(z_cpu_wen),
    .cpu_iom_in(z_cpu_iom), .cpu_ack_out(z_cpu_ack), .cpu_wait_out(z_cpu_wait),
    .dma_req_in(z_dma_req), .dma_a_in(z_dma_a), .dma_d_in(z_dma_d), .dma_wen_in(z_dma_wen),
    .dma_iom_in(z_dma_iom), .dma_ack_out(z_dma_ack), .rdata_out(z_rdata),
    .mem_a_out(z_mem_a), .mem_d_out(z_mem_d), .mem_d_in(z_mem_rd),
    .mem_wen_out(z_mem_wen), .mem_iom_out(z_mem_iom)
  );

  typedef struct packed {
    logic        dma;
    logic [15:0] rdata;
  } exp_t;

  exp_t q1[$];
  exp_t q0[$];
  exp_t e1, e0;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic dma, input logic [15:0] d);
    exp_t e;
    e.dma   = dma;
    e.rdata = d;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors: every ack pops one expected transfer.
  always @(negedge clk) begin
    if (cpu_ack || dma_ack) begin
      check("w1_ack_exclusive", 32'(cpu_ack & dma_ack), 32'd0);
      if (q1.size() == 0) begin
        check("w1_unexpected_ack", 32'({cpu_ack, dma_ack}), 32'd0);
      end else begin
        e1 = q1.pop_front();
        check("w1_ack_owner", 32'(dma_ack), 32'(e1.dma));
        check("w1_ack_rdata", 32'(rdata), 32'(e1.rdata));
      end
    end
  end

  always @(negedge clk) begin
    if (z_cpu_ack || z_dma_ack) begin
      check("w0_ack_exclusive", 32'(z_cpu_ack & z_dma_ack), 32'd0);
      if (q0.size() == 0) begin
        check("w0_unexpected_ack", 32'({z_cpu_ack, z_dma_ack}), 32'd0);
      end else begin
        e0 = q0.pop_front();
        check("w0_ack_owner", 32'(z_dma_ack), 32'(e0.dma));
        check("w0_ack_rdata", 32'(z_rdata), 32'(e0.rdata));
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n   = 1'b0;
    cpu_req = 0; cpu_wen = 0; cpu_iom = 0; cpu_a = '0; cpu_d = '0;
    dma_req = 0; dma_wen = 0; dma_iom = 0; dma_a = '0; dma_d = '0; mem_rd = '0;
    z_cpu_req = 0; z_cpu_wen = 0; z_cpu_iom = 0; z_cpu_a = '0; z_cpu_d = '0;
    z_dma_req = 0; z_dma_wen = 0; z_dma_iom = 0; z_dma_a = '0; z_dma_d = '0; z_mem_rd = '0;

    // Reset held with both requests high
    cpu_req = 1; dma_req = 1; cpu_a = 16'h0100; dma_a = 16'h0200; mem_rd = 16'h0A0A;
    repeat (2) tick();
    #1;
    check("rst_mem_a", 32'(mem_a), 32'd0);
    check("rst_mem_d", 32'(mem_d), 32'd0);
    check("rst_mem_wen", 32'(mem_wen), 32'd0);
    check("rst_mem_iom", 32'(mem_iom), 32'd0);
    check("rst_acks", 32'({cpu_ack, dma_ack}), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    q1.push_back(mk(1'b0, 16'h0A0A));
    rst_n = 1'b1;
    tick();
    check("rst_first_grant_a", 32'(mem_a), 32'h0100);
    cpu_req = 0; dma_req = 0;
    repeat (2) tick();
    check("rst_first_ack", 32'(cpu_ack), 32'd1);
    tick();

    // CPU read, W=1
    cpu_a = 16'h0010; cpu_wen = 0; mem_rd = 16'hBEEF;
    q1.push_back(mk(1'b0, 16'hBEEF));
    cpu_req = 1;
    #1;
    check("rd_wait_c0", 32'(cpu_wait), 32'd1);
    for (int c = 1; c <= 2; c++) begin
      tick();
      check("rd_mem_a_busy", 32'(mem_a), 32'h0010);
      check("rd_mem_wen_busy", 32'(mem_wen), 32'd0);
      check("rd_wait_busy", 32'(cpu_wait), 32'd1);
      check("rd_no_early_ack", 32'(cpu_ack), 32'd0);
    end
    tick();
    check("rd_ack_c3", 32'(cpu_ack), 32'd1);
    check("rd_rdata_c3", 32'(rdata), 32'hBEEF);
    check("rd_wait_c3", 32'(cpu_wait), 32'd0);
    cpu_req = 0;
    tick();
    check("rd_ack_gone_c4", 32'(cpu_ack), 32'd0);
    check("rd_bus_idle_c4", 32'(mem_a), 32'd0);

    // DMA IO write, W=0
    z_dma_a = 16'h8000; z_dma_d = 16'h1234; z_dma_wen = 1; z_dma_iom = 1; z_mem_rd = 16'h0F0F;
    q0.push_back(mk(1'b1, 16'h0F0F));
    z_dma_req = 1;
    tick();
    check("w0_wen_c1", 32'(z_mem_wen), 32'd1);
    check("w0_iom_c1", 32'(z_mem_iom), 32'd1);
    check("w0_d_c1", 32'(z_mem_d), 32'h1234);
    check("w0_a_c1", 32'(z_mem_a), 32'h8000);
    z_dma_req = 0;
    tick();
    check("w0_wen_c2", 32'(z_mem_wen), 32'd0);
    check("w0_ack_c2", 32'(z_dma_ack), 32'd1);
    tick();
    check("w0_ack_c3", 32'(z_dma_ack), 32'd0);
    check("w0_iom_c3", 32'(z_mem_iom), 32'd0);

    // Continuous contention for four transfers
    cpu_a = 16'h0300; dma_a = 16'h0400; mem_rd = 16'h5A5A;
`ifdef ARB_ROUND_ROBIN_EN
    q1.push_back(mk(1'b0, 16'h5A5A)); q1.push_back(mk(1'b1, 16'h5A5A));
    q1.push_back(mk(1'b0, 16'h5A5A)); q1.push_back(mk(1'b1, 16'h5A5A));
`else
    repeat (4) q1.push_back(mk(1'b0, 16'h5A5A));
`endif
    cpu_req = 1; dma_req = 1;
    repeat (15) tick();
`ifdef ARB_ROUND_ROBIN_EN
    check("contend_4th_owner_dma", 32'(dma_ack), 32'd1);
`else
    check("contend_4th_owner_cpu", 32'(cpu_ack), 32'd1);
`endif
    cpu_req = 0; dma_req = 0;
    repeat (2) tick();
    check("contend_drained", 32'(q1.size()), 32'd0);

    // Request dropped and address changed mid-BUSY
    cpu_a = 16'h0020; cpu_wen = 0; mem_rd = 16'h1111;
    q1.push_back(mk(1'b0, 16'h1111));
    cpu_req = 1;
    tick();
    cpu_req = 0; cpu_a = 16'hFFFF;
    #1;
    check("drop_mem_a_c1", 32'(mem_a), 32'h0020);
    tick();
    check("drop_mem_a_c2", 32'(mem_a), 32'h0020);
    tick();
    check("drop_ack_c3", 32'(cpu_ack), 32'd1);
    check("drop_mem_a_c3", 32'(mem_a), 32'h0020);
    tick();

    // Async reset in the middle of a write
    cpu_a = 16'h0030; cpu_d = 16'hCAFE; cpu_wen = 1;
    cpu_req = 1;
    tick();
    check("arst_wen_before", 32'(mem_wen), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_wen_dropped", 32'(mem_wen), 32'd0);
    check("arst_mem_a_cleared", 32'(mem_a), 32'd0);
    cpu_req = 0; cpu_wen = 0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    cpu_a = 16'h0040; mem_rd = 16'h7777;
    q1.push_back(mk(1'b0, 16'h7777));
    cpu_req = 1;
    tick();
    check("arst_new_grant_a", 32'(mem_a), 32'h0040);
    cpu_req = 0;
    repeat (2) tick();
    check("arst_new_ack", 32'(cpu_ack), 32'd1);
    repeat (2) tick();

    check("sb_w1_empty", 32'(q1.size()), 32'd0);
    check("sb_w0_empty", 32'(q0.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
